// File: rtl/aes_rx_frame_ctrl.sv
// UART-to-AES framing controller: decodes a command byte, collects a 16-byte
// block and either loads the AES key or launches an encrypt/decrypt operation.
module aes_rx_frame_ctrl #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int TIMEOUT_US = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_byte,
    input  logic         rx_valid,
    input  logic         aes_done,
    output logic [127:0] aes_key,
    output logic [127:0] aes_data,
    output logic         aes_mode,
    output logic         aes_start,
    output logic         key_valid,
    output logic         busy,
    output logic         frame_err,
    output logic [1:0]   err_code
);

    localparam int TIMEOUT_CYC = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
    localparam int TMO_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CMD_KEY = 8'hA5;
    localparam logic [7:0] CMD_ENC = 8'h5E;
    localparam logic [7:0] CMD_DEC = 8'h5D;

    localparam logic [1:0] ERR_CMD     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COLLECT   = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [127:0]       stage_q,     stage_d;
    logic [3:0]         cnt_q,       cnt_d;
    logic [TMO_W-1:0]   tmo_q,       tmo_d;
    logic               cmd_key_q,   cmd_key_d;
    logic               cmd_dec_q,   cmd_dec_d;
    logic [127:0]       key_q,       key_d;
    logic [127:0]       data_q,      data_d;
    logic               mode_q,      mode_d;
    logic               kv_q,        kv_d;
    logic               err_q,       err_d;
    logic [1:0]         code_q,      code_d;

    logic [127:0]       stage_shift;
    logic               cmd_ok;

    assign stage_shift = {stage_q[119:0], rx_byte};
    // Data commands are only meaningful once a key exists.
    assign cmd_ok = (rx_byte == CMD_KEY) ||
                    (((rx_byte == CMD_ENC) || (rx_byte == CMD_DEC)) && kv_q);

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        cmd_key_d = cmd_key_q;
        cmd_dec_d = cmd_dec_q;
        key_d     = key_q;
        data_d    = data_q;
        mode_d    = mode_q;
        kv_d      = kv_q;
        err_d     = 1'b0;
        code_d    = code_q;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (cmd_ok) begin
                        cmd_key_d = (rx_byte == CMD_KEY);
                        cmd_dec_d = (rx_byte == CMD_DEC);
                        cnt_d     = 4'd0;
                        tmo_d     = '0;
                        state_d   = COLLECT;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CMD;
                    end
                end
            end

            COLLECT: begin
                // A byte in the expiry cycle wins over the timeout.
                if (rx_valid) begin
                    stage_d = stage_shift;
                    tmo_d   = '0;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        if (cmd_key_q) begin
                            key_d   = stage_shift;
                            kv_d    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            data_d  = stage_shift;
                            mode_d  = cmd_dec_q;
                            state_d = START;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    tmo_d   = '0;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            START: begin
                state_d = WAIT_DONE;
                if (rx_valid) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
            end

            WAIT_DONE: begin
                if (aes_done) begin
                    state_d = IDLE;
                end
                if (rx_valid) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            cmd_key_q <= 1'b0;
            cmd_dec_q <= 1'b0;
            key_q     <= '0;
            data_q    <= '0;
            mode_q    <= 1'b0;
            kv_q      <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            cmd_key_q <= cmd_key_d;
            cmd_dec_q <= cmd_dec_d;
            key_q     <= key_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            kv_q      <= kv_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign aes_key   = key_q;
    assign aes_data  = data_q;
    assign aes_mode  = mode_q;
    assign aes_start = (state_q == START);
    assign key_valid = kv_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_aes_rx_frame_ctrl.sv
// Self-checking bench: directed scenarios plus randomized frames, compared every
// cycle against a transaction-level reference model.
module tb_aes_rx_frame_ctrl;

    localparam int CLK_FREQ   = 10_000_000;
    localparam int TIMEOUT_US = 5;
    localparam int T_CYC      = (CLK_FREQ / 1_000_000) * TIMEOUT_US;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         rx_valid = 1'b0;
    logic         aes_done = 1'b0;
    logic [127:0] aes_key;
    logic [127:0] aes_data;
    logic         aes_mode;
    logic         aes_start;
    logic         key_valid;
    logic         busy;
    logic         frame_err;
    logic [1:0]   err_code;

    always #5 clk = ~clk;

    aes_rx_frame_ctrl #(
        .CLK_FREQ  (CLK_FREQ),
        .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .aes_done (aes_done),
        .aes_key  (aes_key),
        .aes_data (aes_data),
        .aes_mode (aes_mode),
        .aes_start(aes_start),
        .key_valid(key_valid),
        .busy     (busy),
        .frame_err(frame_err),
        .err_code (err_code)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 start cycle, 3 awaiting done.
    int           m_phase  = 0;
    logic [7:0]   m_cmd    = 8'h00;
    logic [7:0]   m_bytes[$];
    int           m_silent = 0;
    logic [127:0] e_key    = '0;
    logic [127:0] e_data   = '0;
    logic         e_mode   = 1'b0;
    logic         e_kv     = 1'b0;
    logic         e_err    = 1'b0;
    logic [1:0]   e_code   = 2'd0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] pack_bytes();
        logic [127:0] p = '0;
        for (int i = 0; i < 16; i++)
            p = p | (128'(m_bytes[i]) << (8 * (15 - i)));
        return p;
    endfunction

    task automatic model_update(input logic rst, input logic v, input logic [7:0] b, input logic d);
        e_err = 1'b0;
        if (!rst) begin
            m_phase = 0; m_silent = 0; m_bytes.delete();
            e_key = '0; e_data = '0; e_mode = 1'b0; e_kv = 1'b0; e_code = 2'd0;
            return;
        end
        case (m_phase)
            0: if (v) begin
                if (b == 8'hA5 || ((b == 8'h5E || b == 8'h5D) && e_kv)) begin
                    m_cmd = b; m_bytes.delete(); m_silent = 0; m_phase = 1;
                end else begin
                    e_err = 1'b1; e_code = 2'd1;
                end
            end
            1: if (v) begin
                m_bytes.push_back(b);
                m_silent = 0;
                if (m_bytes.size() == 16) begin
                    if (m_cmd == 8'hA5) begin
                        e_key = pack_bytes(); e_kv = 1'b1; m_phase = 0;
                    end else begin
                        e_data = pack_bytes(); e_mode = (m_cmd == 8'h5D); m_phase = 2;
                    end
                end
            end else begin
                m_silent++;
                if (m_silent == T_CYC) begin
                    e_err = 1'b1; e_code = 2'd2; m_phase = 0;
                end
            end
            2: begin
                if (v) begin e_err = 1'b1; e_code = 2'd3; end
                m_phase = 3;
            end
            default: begin
                if (v) begin e_err = 1'b1; e_code = 2'd3; end
                if (d) m_phase = 0;
            end
        endcase
    endtask

    task automatic check_all();
        check_eq("aes_key",   aes_key,   e_key);
        check_eq("aes_data",  aes_data,  e_data);
        check_eq("aes_mode",  128'(aes_mode),  128'(e_mode));
        check_eq("aes_start", 128'(aes_start), 128'(m_phase == 2));
        check_eq("key_valid", 128'(key_valid), 128'(e_kv));
        check_eq("busy",      128'(busy),      128'(m_phase != 0));
        check_eq("frame_err", 128'(frame_err), 128'(e_err));
        check_eq("err_code",  128'(err_code),  128'(e_code));
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic d);
        rx_valid = v; rx_byte = b; aes_done = d;
        @(posedge clk);
        model_update(rst_n, v, b, d);
        #1;
        check_all();
        rx_valid = 1'b0; aes_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_block(input logic [127:0] blk);
        logic [127:0] tmp = blk;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, tmp[127:120], 1'b0);
            tmp = tmp << 8;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    logic [127:0] key_blk  = 128'h000102030405060708090A0B0C0D0E0F;
    logic [127:0] data_blk = 128'h00112233445566778899AABBCCDDEEFF;
    logic [127:0] saved;

    initial begin
        do_reset();
        check_eq("reset_key", aes_key, '0);
        check_eq("reset_busy", 128'(busy), '0);

        // Data command with no key loaded.
        step(1'b1, 8'h5D, 1'b0);
        check_eq("nokey_err", 128'(frame_err), 128'(1));
        check_eq("nokey_code", 128'(err_code), 128'(1));
        check_eq("nokey_busy", 128'(busy), '0);
        $display("txn: decrypt without key");

        // Key load.
        step(1'b1, 8'hA5, 1'b0);
        send_block(key_blk);
        check_eq("keyload_key", aes_key, key_blk);
        check_eq("keyload_valid", 128'(key_valid), 128'(1));
        check_eq("keyload_start", 128'(aes_start), '0);
        idle(2);
        $display("txn: key load %h", aes_key);

        // Encrypt: start exactly one cycle after the last byte, busy until done.
        step(1'b1, 8'h5E, 1'b0);
        send_block(data_blk);
        check_eq("enc_data", aes_data, data_blk);
        check_eq("enc_mode", 128'(aes_mode), '0);
        check_eq("enc_start", 128'(aes_start), 128'(1));
        idle(3);
        check_eq("enc_busy_wait", 128'(busy), 128'(1));
        step(1'b0, 8'h00, 1'b1);
        check_eq("enc_done_idle", 128'(busy), '0);
        $display("txn: encrypt %h", aes_data);

        // Timeout after 5 payload bytes.
        saved = aes_key;
        step(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'hF0 + 8'(i), 1'b0);
        idle(T_CYC);
        check_eq("tmo_code", 128'(err_code), 128'(2));
        check_eq("tmo_key", aes_key, saved);
        check_eq("tmo_idle", 128'(busy), '0);
        $display("txn: timeout");

        // Overrun during WAIT_DONE.
        step(1'b1, 8'h5D, 1'b0);
        send_block(~data_blk);
        idle(1);
        step(1'b1, 8'h77, 1'b0);
        check_eq("ovr_code", 128'(err_code), 128'(3));
        check_eq("ovr_data", aes_data, ~data_blk);
        check_eq("ovr_busy", 128'(busy), 128'(1));
        step(1'b0, 8'h00, 1'b1);
        check_eq("ovr_idle", 128'(busy), '0);
        $display("txn: overrun");

        // Reset mid-frame, then full sequence.
        step(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0);
        do_reset();
        check_eq("midrst_key", aes_key, '0);
        check_eq("midrst_kv", 128'(key_valid), '0);
        step(1'b1, 8'hA5, 1'b0);
        send_block(key_blk);
        step(1'b1, 8'h5E, 1'b0);
        send_block(data_blk);
        check_eq("midrst_start", 128'(aes_start), 128'(1));
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check_eq("midrst_done", 128'(busy), '0);
        $display("txn: reset mid-frame recovery");

        // Randomized frames with gaps at and around the timeout boundary.
        for (int f = 0; f < 40; f++) begin
            logic [7:0] cmd;
            int sel = $urandom_range(0, 5);
            cmd = (sel < 2) ? 8'hA5 : (sel < 4) ? 8'h5E : (sel == 4) ? 8'h5D : 8'($urandom);
            step(1'b1, cmd, 1'b0);
            for (int i = 0; i < 16; i++) begin
                int r = $urandom_range(0, 19);
                int gap = (r == 0) ? T_CYC : (r == 1) ? T_CYC - 1 : $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) step(1'b0, 8'h00, 1'($urandom_range(0, 3) == 0));
                step(1'b1, 8'($urandom), 1'b0);
            end
            for (int w = $urandom_range(0, 4); w > 0; w--)
                step(1'($urandom_range(0, 4) == 0), 8'($urandom), 1'b0);
            step(1'b0, 8'h00, 1'b1);
            if ($urandom_range(0, 9) == 0) do_reset();
            $display("txn: random frame %0d cmd=%h key_valid=%0b", f, cmd, key_valid);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
